// File: rtl/spi_event_responder_if.sv
// SPI link between the bedside controller (master) and the event responder (slave).
interface spi_event_responder_if;
    logic sclk;
    logic mosi;
    logic cs_n;
    logic miso;

    modport master (output sclk, mosi, cs_n, input miso);
    modport slave  (input sclk, mosi, cs_n, output miso);
endinterface

// File: rtl/spi_event_responder.sv
// Oversampled SPI mode-0 responder that reports latched lev/day events and
// clears the reported ones when the master sends the read command.
//
// state | meaning
// IDLE  | no frame, miso low, waiting for cs_n to fall
// SHIFT | frame active, exchanging bits on sclk edges
// DONE  | full byte received, ignore sclk until cs_n rises
module spi_event_responder #(
    parameter int                  DATABITS = 8,
    parameter logic [DATABITS-1:0] CMD_READ = 8'h02,
    parameter int                  CNTB     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    spi_event_responder_if.slave      spi,
    input  logic                      ev_lev,
    input  logic                      ev_day,
    output logic [DATABITS-1:0]       rx_byte,
    output logic                      rx_dv,
    output logic                      pend_lev,
    output logic                      pend_day,
    output logic [CNTB-1:0]           lev_cnt,
    output logic                      busy
);
    localparam int BW = $clog2(DATABITS);
    localparam int CW = (CNTB < 4) ? CNTB : 4;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_next;

    logic [1:0] sclk_s, mosi_s, cs_s;
    logic       sclk_q, cs_q;
    logic       sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [DATABITS-1:0] tx_sr, rx_sr, rx_next, status;
    logic [BW-1:0]       bit_cnt;
    logic                miso_q;
    logic                snap_lev, snap_day, late_lev, late_day;
    logic [CNTB-1:0]     snap_cnt;
    logic                load, shift_rx, shift_tx, finish, abort, clear;
    logic                pend_lev_next, pend_day_next;
    logic [CNTB-1:0]     lev_cnt_next;
    logic [CNTB:0]       remain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s <= 2'b00;
            mosi_s <= 2'b00;
            cs_s   <= 2'b11;
            sclk_q <= 1'b0;
            cs_q   <= 1'b1;
        end else begin
            sclk_s <= {sclk_s[0], spi.sclk};
            mosi_s <= {mosi_s[0], spi.mosi};
            cs_s   <= {cs_s[0], spi.cs_n};
            sclk_q <= sclk_s[1];
            cs_q   <= cs_s[1];
        end
    end

    assign sclk_rise = sclk_s[1] & ~sclk_q;
    assign sclk_fall = ~sclk_s[1] & sclk_q;
    assign cs_fall   = ~cs_s[1] & cs_q;
    assign cs_rise   = cs_s[1] & ~cs_q;
    assign rx_next   = {rx_sr[DATABITS-2:0], mosi_s[1]};
    assign clear     = finish && (rx_next == CMD_READ);
    assign busy      = (state != IDLE);
    assign spi.miso  = miso_q;

    always_comb begin
        status                   = '0;
        status[DATABITS-1]       = pend_lev;
        status[DATABITS-2]       = pend_day;
        status[CW-1:0]           = lev_cnt[CW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_rx   = 1'b0;
        shift_tx   = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (sclk_rise) begin
                    shift_rx = 1'b1;
                    if (bit_cnt == BW'(DATABITS - 1)) begin
                        finish     = 1'b1;
                        state_next = DONE;
                    end
                end else if (sclk_fall) begin
                    shift_tx = 1'b1;
                end
            end
            DONE: begin
                if (cs_rise) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            miso_q   <= 1'b0;
            rx_byte  <= '0;
            rx_dv    <= 1'b0;
            snap_lev <= 1'b0;
            snap_day <= 1'b0;
            snap_cnt <= '0;
            late_lev <= 1'b0;
            late_day <= 1'b0;
        end else begin
            rx_dv    <= finish;
            // Events seen after the snapshot must survive the clear.
            late_lev <= (load ? 1'b0 : late_lev) | ev_lev;
            late_day <= (load ? 1'b0 : late_day) | ev_day;
            if (load) begin
                tx_sr    <= status;
                miso_q   <= status[DATABITS-1];
                bit_cnt  <= '0;
                snap_lev <= pend_lev;
                snap_day <= pend_day;
                snap_cnt <= lev_cnt;
            end
            if (shift_rx) begin
                rx_sr   <= rx_next;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_tx) begin
                tx_sr  <= tx_sr << 1;
                miso_q <= tx_sr[DATABITS-2];
            end
            if (finish) begin
                rx_byte <= rx_next;
                miso_q  <= 1'b0;
            end
            if (abort) miso_q <= 1'b0;
        end
    end

    always_comb begin
        remain        = {1'b0, lev_cnt} - {1'b0, snap_cnt} + (CNTB+1)'(ev_lev);
        pend_lev_next = pend_lev | ev_lev;
        pend_day_next = pend_day | ev_day;
        lev_cnt_next  = (ev_lev && lev_cnt != '1) ? lev_cnt + 1'b1 : lev_cnt;
        if (clear) begin
            pend_lev_next = (pend_lev & ~snap_lev) | late_lev | ev_lev;
            pend_day_next = (pend_day & ~snap_day) | late_day | ev_day;
            lev_cnt_next  = remain[CNTB] ? '1 : remain[CNTB-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_lev <= 1'b0;
            pend_day <= 1'b0;
            lev_cnt  <= '0;
        end else begin
            pend_lev <= pend_lev_next;
            pend_day <= pend_day_next;
            lev_cnt  <= lev_cnt_next;
        end
    end
endmodule

// File: tb/tb_spi_event_responder.sv
// Directed plus randomized frames against a counting model of pending events.
module tb_spi_event_responder;
    localparam int          HALF     = 6;
    localparam logic [7:0]  CMD_READ = 8'h02;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ev_lev = 1'b0;
    logic       ev_day = 1'b0;
    logic [7:0] rx_byte;
    logic       rx_dv;
    logic       pend_lev, pend_day, busy;
    logic [3:0] lev_cnt;

    spi_event_responder_if spi();

    spi_event_responder #(.DATABITS(8), .CMD_READ(8'h02), .CNTB(4)) dut (
        .clk(clk), .rst(rst), .spi(spi), .ev_lev(ev_lev), .ev_day(ev_day),
        .rx_byte(rx_byte), .rx_dv(rx_dv), .pend_lev(pend_lev),
        .pend_day(pend_day), .lev_cnt(lev_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int dv_cnt = 0;

    always @(negedge clk) if (rx_dv === 1'b1) dv_cnt++;

    bit m_lev = 0;
    bit m_day = 0;
    int m_cnt = 0;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_status();
        return {m_lev, m_day, 2'b00, 4'(m_cnt)};
    endfunction

    task automatic ev_pulse(input bit l, input bit d);
        @(negedge clk);
        ev_lev = l;
        ev_day = d;
        @(negedge clk);
        ev_lev = 1'b0;
        ev_day = 1'b0;
        if (l) begin
            m_lev = 1;
            if (m_cnt < 15) m_cnt++;
        end
        if (d) m_day = 1;
    endtask

    task automatic apply_read(input bit sl, input bit sd, input int sc, input bit ll, input bit ld);
        m_cnt = m_cnt - sc;
        m_lev = ll | (m_lev & ~sl);
        m_day = ld | (m_day & ~sd);
    endtask

    task automatic run_frame(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        wait_clk(2);
        spi.cs_n = 1'b0;
        spi.mosi = tx[7];
        wait_clk(HALF);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi.sclk = 1'b1;
            rx = {rx[6:0], spi.miso};
            wait_clk(HALF);
            spi.sclk = 1'b0;
            if (i < 7) spi.mosi = tx[6-i];
            wait_clk(HALF);
        end
        spi.cs_n = 1'b1;
        spi.mosi = 1'b0;
        wait_clk(6);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_pend_lev"}, pend_lev, m_lev);
        chk({tag, "_pend_day"}, pend_day, m_day);
        chk({tag, "_lev_cnt"}, lev_cnt, m_cnt);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_miso_idle"}, spi.miso, 0);
    endtask

    task automatic do_frame(input string tag, input logic [7:0] cmd);
        logic [7:0] exp_st, got;
        int dv0, sc;
        bit sl, sd;
        exp_st = model_status();
        sl = m_lev; sd = m_day; sc = m_cnt; dv0 = dv_cnt;
        run_frame(cmd, 8, got);
        chk({tag, "_miso"}, got, exp_st);
        chk({tag, "_rx_byte"}, rx_byte, cmd);
        chk({tag, "_rx_dv"}, dv_cnt - dv0, 1);
        if (cmd == CMD_READ) apply_read(sl, sd, sc, 0, 0);
        check_state(tag);
    endtask

    initial begin
        logic [7:0] got, exp_st, last_rx, cmd;
        int dv0, sc, nl;
        bit sl, sd;

        spi.sclk = 1'b0;
        spi.mosi = 1'b0;
        spi.cs_n = 1'b1;
        wait_clk(3);
        chk("reset_rx_byte", rx_byte, 0);
        chk("reset_rx_dv", rx_dv, 0);
        check_state("reset");
        rst = 1'b0;
        wait_clk(3);

        // Basic read of three presses and a day tick.
        repeat (3) ev_pulse(1, 0);
        ev_pulse(0, 1);
        wait_clk(2);
        check_state("t1_pre");
        do_frame("t1_read", 8'h02);

        // Non-read byte leaves pending state alone.
        repeat (2) ev_pulse(1, 0);
        do_frame("t2_other", 8'hA5);
        do_frame("t2_read", 8'h02);

        // Press arriving mid-frame after the snapshot survives the clear.
        ev_pulse(1, 0);
        exp_st = model_status();
        sl = m_lev; sd = m_day; sc = m_cnt; dv0 = dv_cnt;
        fork
            run_frame(8'h02, 8, got);
            begin wait_clk(40); ev_pulse(1, 0); end
        join
        apply_read(sl, sd, sc, 1, 0);
        chk("t3_miso", got, exp_st);
        chk("t3_rx_dv", dv_cnt - dv0, 1);
        check_state("t3_post");
        do_frame("t3_read", 8'h02);

        // Saturation of the press counter.
        repeat (20) ev_pulse(1, 0);
        wait_clk(2);
        check_state("t4_sat");
        do_frame("t4_read", 8'h02);

        // Aborted frame after five bits.
        ev_pulse(1, 1);
        exp_st = model_status();
        last_rx = rx_byte;
        dv0 = dv_cnt;
        run_frame(8'h02, 5, got);
        chk("t5_partial_miso", got[4:0], exp_st[7:3]);
        chk("t5_rx_dv", dv_cnt - dv0, 0);
        chk("t5_rx_byte", rx_byte, last_rx);
        check_state("t5_abort");
        do_frame("t5_after", 8'h02);

        // Randomized event mixes and commands.
        for (int it = 0; it < 12; it++) begin
            nl = int'($urandom_range(0, 6));
            for (int k = 0; k < nl; k++) ev_pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
            cmd = ($urandom_range(0, 1) == 1) ? CMD_READ : 8'($urandom);
            do_frame($sformatf("rand%0d", it), cmd);
        end

        // Reset in the middle of a frame.
        repeat (2) ev_pulse(1, 0);
        fork
            run_frame(8'h02, 8, got);
            begin
                wait_clk(2 + HALF + 3 * 2 * HALF + 3);
                chk("t6_busy_mid", busy, 1);
                rst = 1'b1;
                #1;
                chk("t6_rst_miso", spi.miso, 0);
                chk("t6_rst_rx_byte", rx_byte, 0);
                chk("t6_rst_rx_dv", rx_dv, 0);
                chk("t6_rst_pend_lev", pend_lev, 0);
                chk("t6_rst_pend_day", pend_day, 0);
                chk("t6_rst_lev_cnt", lev_cnt, 0);
                chk("t6_rst_busy", busy, 0);
            end
        join
        m_lev = 0; m_day = 0; m_cnt = 0;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(3);
        do_frame("t6_after", 8'h02);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_event_responder.md
Name: spi_event_responder

Overview:
- SPI peripheral-side responder: the far end of the bedside controller's SPI master link.
- Latches sensor-side events: lev-button presses and the 24h bag-change tick.
- The master polls it with one command byte per chip-select frame; the responder returns a status byte in the same frame.
- A read command clears the events it reported. It runs on the system clock and oversamples SCLK/MOSI/CS.

Parameters:
- DATABITS, 8, SPI frame width in bits.
- CMD_READ, 8'h02, received byte that acknowledges and clears the reported events.
- CNTB, 4, width of the saturating lev-press counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- sclk  input  1  SPI clock from master, mode 0, asynchronous to clk.
- mosi  input  1  master-out data, MSB first.
- cs_n  input  1  slave select, active low.
- ev_lev  input  1  one-clk pulse per debounced lev press.
- ev_day  input  1  one-clk pulse when 24h elapse.
- miso  output  1  slave-out data, MSB first.
- rx_byte  output  DATABITS  last complete byte received.
- rx_dv  output  1  one-clk pulse when rx_byte updates.
- pend_lev  output  1  lev event pending.
- pend_day  output  1  day event pending.
- lev_cnt  output  CNTB  pending lev presses, saturating.
- busy  output  1  high while a frame is active (cs_n low, synchronized).

Behaviour:
- Reset: miso=0, rx_byte=0, rx_dv=0, pend_lev=0, pend_day=0, lev_cnt=0, busy=0, FSM=IDLE, synchronizers=idle levels (sclk=0, cs_n=1).
- Synchronization: sclk, mosi and cs_n each pass through 2 flops; edges are detected from the synchronized values.
- Latency: 2-3 clk from pin to detected edge. SCLK half-period must be at least 4 clk.
- Status byte: {pend_lev, pend_day, 2'b00, lev_cnt} for CNTB=4; the upper fields stay fixed if CNTB changes, and the count is zero-padded/truncated to the low bits.
- FSM IDLE:
  - cs_n falls: snapshot status into tx shift register and into snap_lev/snap_day/snap_cnt; miso=bit7; bit counter=0; go SHIFT; busy=1.
- FSM SHIFT:
  - sclk rise: shift mosi into rx shift register (LSB in); counter++.
  - sclk fall: shift tx left; miso = next bit.
  - On the 8th rise: rx_byte <= assembled byte; rx_dv=1 for one clk; go DONE.
  - If rx byte == CMD_READ, apply clear in the same cycle.
- FSM DONE:
  - miso=0; further sclk edges ignored.
  - cs_n rise -> IDLE, busy=0.
- Abort: cs_n rises in SHIFT before 8 bits -> IDLE; no rx_dv, no clear, rx_byte unchanged, miso=0.
- miso while IDLE: 0.
- Clear rule (CMD_READ only):
  - pend_lev <= pend_lev & ~snap_lev, then OR ev_lev.
  - pend_day <= pend_day & ~snap_day, then OR ev_day.
  - lev_cnt <= sat(lev_cnt - snap_cnt + ev_lev).
  - Events arriving after the snapshot are never lost.
- Event accumulation outside clear:
  - ev_lev sets pend_lev and increments lev_cnt, saturating at 2^CNTB-1.
  - ev_day sets pend_day.
  - Both may pulse in the same cycle.
- Non-CMD_READ byte: rx_dv pulses; pending state is untouched.
- Reset mid-frame: everything returns to reset values immediately. The master's in-flight frame is garbage; the next cs_n fall starts cleanly.
- A cs_n fall while in DONE is impossible (cs_n low); a cs_n glitch narrower than 2 clk may be missed and is not required to be handled.

Test Plan:
- Reset, then ev_lev x3 and ev_day x1 -> pend_lev=1, pend_day=1, lev_cnt=3. Frame sending 8'h02 -> miso shifts 8'hC3, rx_byte=02, rx_dv one pulse, then all pending = 0.
- Frame with master byte 8'hA5 after 2 lev events -> miso 8'h82, rx_byte=A5, pend_lev=1, lev_cnt=2 remain.
- ev_lev pulse mid-frame after snapshot (lev_cnt was 1), frame sends 8'h02 -> miso 8'h81; afterwards pend_lev=1, lev_cnt=1.
- 20 ev_lev pulses -> lev_cnt saturates at 15. Read -> miso 8'h8F, lev_cnt=0.
- cs_n raised after 5 bits of 8'h02 -> no rx_dv, pending unchanged, miso=0, busy=0. A following full frame behaves normally.
- rst asserted during bit 4 -> all outputs 0 the same cycle. After rst release, a frame with 8'h02 returns 8'h00.
